// File: rtl/cpu_stack_writeback_pkg.sv
// Shared constants for the stack writeback slice: push selector codes, type tags, entry layout.
package cpu_stack_writeback_pkg;

  localparam int unsigned UC_W    = 3;
  localparam int unsigned TAG_W   = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH_W = 11;
  localparam int unsigned CALC_W  = 12;

  localparam logic [UC_W-1:0] UC_PUSHNONE = 3'd0;
  localparam logic [UC_W-1:0] UC_PUSHALU  = 3'd1;
  localparam logic [UC_W-1:0] UC_PUSHIMM  = 3'd2;
  localparam logic [UC_W-1:0] UC_PUSHREG0 = 3'd3;
  localparam logic [UC_W-1:0] UC_PUSHREG1 = 3'd4;

  localparam logic [TAG_W-1:0] TYPE_INTEGER   = 3'd0;
  localparam logic [TAG_W-1:0] TYPE_BOOLEAN   = 3'd1;
  localparam logic [TAG_W-1:0] TYPE_REFERENCE = 3'd2;
  localparam logic [TAG_W-1:0] TYPE_CODE      = 3'd3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] payload;
  } stack_entry_t;

endpackage

// File: rtl/cpu_stack_ram.sv
// Operand-stack storage: one synchronous write port, two asynchronous read ports, no reset.
module cpu_stack_ram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ENTRY_W    = 35
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [ENTRY_W-1:0]    i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr0,
  input  logic [DEPTH_LOG2-1:0] i_raddr1,
  output logic [ENTRY_W-1:0]    o_rdata0_c,
  output logic [ENTRY_W-1:0]    o_rdata1_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata0_c = r_mem[i_raddr0];
  assign o_rdata1_c = r_mem[i_raddr1];

endmodule

// File: rtl/cpu_stack_writeback.sv
// Writeback stage: commits each instruction's stack effect, publishes top two entries,
// registers branch redirect and latches a sticky overflow/underflow fault.
module cpu_stack_writeback
  import cpu_stack_writeback_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ENTRY_W    = 35
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [2:0]         c__to_push_4a,
  input  logic [10:0]        st__to_pop_4a,
  input  logic [ENTRY_W-1:0] st__to_push_4a,
  input  logic               kill_4a,
  input  logic [31:0]        branch_target_4a,
  input  logic [31:0]        pc_4a,
  output logic [ENTRY_W-1:0] r0_5a,
  output logic [ENTRY_W-1:0] r1_5a,
  output logic [10:0]        depth_5a,
  output logic               redirect_5a,
  output logic [31:0]        redirect_pc_5a,
  output logic               fault_5a,
  output logic [31:0]        fault_pc_5a
);

  localparam int unsigned CAP = 1 << DEPTH_LOG2;

  logic [DEPTH_W-1:0] r_depth;
  logic [ENTRY_W-1:0] r_r0;
  logic [ENTRY_W-1:0] r_r1;
  logic               r_fault;
  logic [31:0]        r_fault_pc;
  logic               r_redirect;
  logic [31:0]        r_redirect_pc;

  logic                  w_push;
  logic [CALC_W-1:0]     w_depth;
  logic [CALC_W-1:0]     w_pop;
  logic [CALC_W-1:0]     w_base;
  logic [CALC_W-1:0]     w_nd;
  logic                  w_under;
  logic                  w_over;
  logic                  w_commit;
  logic                  w_fault_evt;
  logic [DEPTH_LOG2-1:0] w_waddr;
  logic [DEPTH_LOG2-1:0] w_raddr0;
  logic [DEPTH_LOG2-1:0] w_raddr1;
  logic [ENTRY_W-1:0]    w_rdata0;
  logic [ENTRY_W-1:0]    w_rdata1;
  logic [ENTRY_W-1:0]    w_r0_next;
  logic [ENTRY_W-1:0]    w_r1_next;

  // Commit arithmetic in 12 bits so depth-pop underflow and nd overflow are both visible.
  assign w_push      = (c__to_push_4a != UC_PUSHNONE);
  assign w_depth     = CALC_W'(r_depth);
  assign w_pop       = CALC_W'(st__to_pop_4a);
  assign w_base      = w_depth - w_pop;
  assign w_nd        = w_base + CALC_W'(w_push);
  assign w_under     = (w_pop > w_depth);
  assign w_over      = (w_nd > CALC_W'(CAP));
  assign w_commit    = !r_fault && !w_under && !w_over;
  assign w_fault_evt = !r_fault && (w_under || w_over);

  // Pushed entry lands at depth-pop; the old entry below it becomes r1.
  assign w_waddr  = DEPTH_LOG2'(w_base);
  assign w_raddr0 = DEPTH_LOG2'(w_nd - CALC_W'(1));
  assign w_raddr1 = w_push ? DEPTH_LOG2'(w_base - CALC_W'(1)) : DEPTH_LOG2'(w_nd - CALC_W'(2));

  cpu_stack_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .ENTRY_W    (ENTRY_W)
  ) u_ram (
    .clk        (clk),
    .i_we       (w_commit && w_push),
    .i_waddr    (w_waddr),
    .i_wdata    (st__to_push_4a),
    .i_raddr0   (w_raddr0),
    .i_raddr1   (w_raddr1),
    .o_rdata0_c (w_rdata0),
    .o_rdata1_c (w_rdata1)
  );

  // New top entries; the pushed value bypasses the array write.
  always_comb begin
    w_r0_next = '0;
    w_r1_next = '0;
    if (w_push) w_r0_next = st__to_push_4a;
    else if (w_nd != '0) w_r0_next = w_rdata0;
    if (w_nd >= CALC_W'(2)) w_r1_next = w_rdata1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_depth       <= '0;
      r_r0          <= '0;
      r_r1          <= '0;
      r_fault       <= 1'b0;
      r_fault_pc    <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      if (w_commit) begin
        r_depth <= DEPTH_W'(w_nd);
        r_r0    <= w_r0_next;
        r_r1    <= w_r1_next;
      end
      if (w_fault_evt) begin
        r_fault    <= 1'b1;
        r_fault_pc <= pc_4a;
      end
      if (kill_4a) begin
        r_redirect    <= 1'b1;
        r_redirect_pc <= branch_target_4a;
      end else begin
        r_redirect    <= 1'b0;
      end
    end
  end

  assign r0_5a          = r_r0;
  assign r1_5a          = r_r1;
  assign depth_5a       = r_depth;
  assign redirect_5a    = r_redirect;
  assign redirect_pc_5a = r_redirect_pc;
  assign fault_5a       = r_fault;
  assign fault_pc_5a    = r_fault_pc;

endmodule

// File: tb/tb_cpu_stack_writeback.sv
// Self-checking bench: a 1024-deep and a 4-deep instance share stimulus and are compared
// against queue-based stack models.
module tb_cpu_stack_writeback;
  import cpu_stack_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [2:0]  c_push = '0;
  logic [10:0] pop = '0;
  logic [34:0] pdata = '0;
  logic        kill = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] pc = '0;

  logic [34:0] b_r0, b_r1, s_r0, s_r1;
  logic [10:0] b_depth, s_depth;
  logic        b_redir, s_redir, b_fault, s_fault;
  logic [31:0] b_rpc, s_rpc, b_fpc, s_fpc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [34:0] m_q [2][$];
  bit          m_fault [2];
  logic [31:0] m_fpc [2];
  bit          m_redir [2];
  logic [31:0] m_rpc [2];
  int          m_cap [2] = '{1024, 4};

  always #5 clk = ~clk;

  cpu_stack_writeback #(.DEPTH_LOG2(10), .ENTRY_W(35)) u_dut_big (
    .clk(clk), .rst_b(rst_b), .c__to_push_4a(c_push), .st__to_pop_4a(pop),
    .st__to_push_4a(pdata), .kill_4a(kill), .branch_target_4a(tgt), .pc_4a(pc),
    .r0_5a(b_r0), .r1_5a(b_r1), .depth_5a(b_depth), .redirect_5a(b_redir),
    .redirect_pc_5a(b_rpc), .fault_5a(b_fault), .fault_pc_5a(b_fpc)
  );

  cpu_stack_writeback #(.DEPTH_LOG2(2), .ENTRY_W(35)) u_dut_small (
    .clk(clk), .rst_b(rst_b), .c__to_push_4a(c_push), .st__to_pop_4a(pop),
    .st__to_push_4a(pdata), .kill_4a(kill), .branch_target_4a(tgt), .pc_4a(pc),
    .r0_5a(s_r0), .r1_5a(s_r1), .depth_5a(s_depth), .redirect_5a(s_redir),
    .redirect_pc_5a(s_rpc), .fault_5a(s_fault), .fault_pc_5a(s_fpc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] m_top(input int i, input int k);
    int sz;
    sz = m_q[i].size();
    if (sz > k) return m_q[i][sz-1-k];
    return 35'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_q[i].delete();
      m_fault[i] = 1'b0;
      m_fpc[i]   = '0;
      m_redir[i] = 1'b0;
      m_rpc[i]   = '0;
    end
  endtask

  // Applies the current inputs to both stack models as one commit.
  task automatic model_step();
    int sz, p, nd;
    bit push;
    for (int i = 0; i < 2; i++) begin
      push = (c_push != UC_PUSHNONE);
      sz   = m_q[i].size();
      p    = int'(pop);
      nd   = sz - p + (push ? 1 : 0);
      if (!m_fault[i]) begin
        if (p > sz || nd > m_cap[i]) begin
          m_fault[i] = 1'b1;
          m_fpc[i]   = pc;
        end else begin
          for (int k = 0; k < p; k++) void'(m_q[i].pop_back());
          if (push) m_q[i].push_back(pdata);
        end
      end
      m_redir[i] = kill;
      if (kill) m_rpc[i] = tgt;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".b_r0"}, 64'(b_r0), 64'(m_top(0, 0)));
    check({tag, ".b_r1"}, 64'(b_r1), 64'(m_top(0, 1)));
    check({tag, ".b_depth"}, 64'(b_depth), 64'(m_q[0].size()));
    check({tag, ".b_fault"}, 64'(b_fault), 64'(m_fault[0]));
    check({tag, ".b_fpc"}, 64'(b_fpc), 64'(m_fpc[0]));
    check({tag, ".b_redir"}, 64'(b_redir), 64'(m_redir[0]));
    check({tag, ".b_rpc"}, 64'(b_rpc), 64'(m_rpc[0]));
    check({tag, ".s_r0"}, 64'(s_r0), 64'(m_top(1, 0)));
    check({tag, ".s_r1"}, 64'(s_r1), 64'(m_top(1, 1)));
    check({tag, ".s_depth"}, 64'(s_depth), 64'(m_q[1].size()));
    check({tag, ".s_fault"}, 64'(s_fault), 64'(m_fault[1]));
    check({tag, ".s_fpc"}, 64'(s_fpc), 64'(m_fpc[1]));
    check({tag, ".s_redir"}, 64'(s_redir), 64'(m_redir[1]));
    check({tag, ".s_rpc"}, 64'(s_rpc), 64'(m_rpc[1]));
  endtask

  task automatic cycle(input string tag, input logic [2:0] c, input int p, input logic [34:0] d,
                       input logic k, input logic [31:0] t, input logic [31:0] a);
    c_push = c; pop = 11'(p); pdata = d; kill = k; tgt = t; pc = a;
    @(posedge clk);
    #1;
    model_step();
    check_outputs(tag);
  endtask

  task automatic bubble(input string tag);
    cycle(tag, UC_PUSHNONE, 0, 35'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // Asserts reset between clock edges so the clear must be asynchronous.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_b = 1'b0;
    c_push = UC_PUSHNONE; pop = '0; kill = 1'b0;
    #1;
    model_clear();
    check_outputs(tag);
    @(posedge clk);
    #2;
    rst_b = 1'b1;
  endtask

  function automatic logic [34:0] mk(input logic [2:0] tag, input logic [31:0] v);
    stack_entry_t e;
    e.tag = tag;
    e.payload = v;
    return e;
  endfunction

  initial begin
    logic [2:0] rc;
    int rp;
    model_clear();
    #12;
    rst_b = 1'b1;

    do_reset("rst0");
    cycle("t1a", UC_PUSHIMM, 0, 35'h5, 1'b0, 32'h0, 32'h10);
    cycle("t1b", UC_PUSHIMM, 0, 35'h7, 1'b0, 32'h0, 32'h14);
    check("t1.depth", 64'(b_depth), 64'd2);
    check("t1.r0", 64'(b_r0), 64'd7);
    check("t1.r1", 64'(b_r1), 64'd5);

    cycle("t2", UC_PUSHALU, 2, 35'hC, 1'b0, 32'h0, 32'h18);
    check("t2.depth", 64'(b_depth), 64'd1);
    check("t2.r0", 64'(b_r0), 64'd12);
    check("t2.r1", 64'(b_r1), 64'd0);

    cycle("t3a", UC_PUSHNONE, 2, 35'h0, 1'b0, 32'h0, 32'h100);
    check("t3.fault", 64'(b_fault), 64'd1);
    check("t3.fpc", 64'(b_fpc), 64'h100);
    check("t3.depth", 64'(b_depth), 64'd1);
    cycle("t3b", UC_PUSHNONE, 5, 35'h0, 1'b0, 32'h0, 32'h200);
    check("t3.fpc_sticky", 64'(b_fpc), 64'h100);
    cycle("t3c", UC_PUSHIMM, 0, 35'h9, 1'b0, 32'h0, 32'h204);

    do_reset("rst4a");
    for (int i = 0; i < 4; i++) cycle("t4a", UC_PUSHIMM, 0, mk(TYPE_INTEGER, 32'(i + 1)), 1'b0, 32'h0, 32'h300);
    cycle("t4a5", UC_PUSHREG0, 0, mk(TYPE_CODE, 32'hAA), 1'b0, 32'h0, 32'h310);
    check("t4a.fault", 64'(s_fault), 64'd1);
    check("t4a.depth", 64'(s_depth), 64'd4);
    do_reset("rst4b");
    for (int i = 0; i < 4; i++) cycle("t4b", UC_PUSHIMM, 0, mk(TYPE_BOOLEAN, 32'(i + 1)), 1'b0, 32'h0, 32'h400);
    cycle("t4b5", UC_PUSHREG1, 1, mk(TYPE_REFERENCE, 32'hBB), 1'b0, 32'h0, 32'h410);
    check("t4b.fault", 64'(s_fault), 64'd0);
    check("t4b.depth", 64'(s_depth), 64'd4);
    check("t4b.r0", 64'(s_r0), 64'(mk(TYPE_REFERENCE, 32'hBB)));

    cycle("t5a", UC_PUSHNONE, 1, 35'h0, 1'b1, 32'h40, 32'h500);
    check("t5.redir", 64'(s_redir), 64'd1);
    check("t5.rpc", 64'(s_rpc), 64'h40);
    check("t5.depth", 64'(s_depth), 64'd3);
    bubble("t5b");
    check("t5.redir_pulse", 64'(b_redir), 64'd0);
    check("t5.rpc_hold", 64'(b_rpc), 64'h40);

    do_reset("rst6a");
    for (int i = 0; i < 3; i++) cycle("t6a", UC_PUSHALU, 0, 35'(32'hC0 + i), 1'b1, 32'h80, 32'h600);
    do_reset("rst6b");
    check("t6.depth0", 64'(b_depth), 64'd0);
    check("t6.rpc0", 64'(b_rpc), 64'd0);
    cycle("t6b", UC_PUSHIMM, 0, 35'h1234, 1'b0, 32'h0, 32'h610);
    check("t6.depth", 64'(b_depth), 64'd1);
    check("t6.r1", 64'(b_r1), 64'd0);

    // Boundary: pop everything with and without a push.
    cycle("bd1", UC_PUSHIMM, 0, 35'h22, 1'b0, 32'h0, 32'h700);
    cycle("bd2", UC_PUSHNONE, 2, 35'h0, 1'b0, 32'h0, 32'h704);
    cycle("bd3", UC_PUSHIMM, 0, 35'h33, 1'b0, 32'h0, 32'h708);
    cycle("bd4", UC_PUSHALU, 1, 35'h44, 1'b0, 32'h0, 32'h70C);

    for (int n = 0; n < 1200; n++) begin
      if (n % 150 == 149) do_reset("rrst");
      rc = ($urandom_range(0, 9) < 3) ? UC_PUSHNONE : 3'($urandom_range(1, 4));
      rp = ($urandom_range(0, 99) < 3) ? $urandom_range(0, 2047) : $urandom_range(0, 2);
      cycle("rnd", rc, rp, {3'($urandom_range(0, 7)), 32'($urandom)},
            1'($urandom_range(0, 3) == 0), 32'($urandom), 32'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
